// File: rtl/csa_resolve.sv
// csa_resolve: resolves a carry-save (s, c) pair into binary s + (c << 1),
// adding CW bits per cycle so the carry chain stays short at large DW.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, s, c (operand side);
//        out_valid/out_ready, sum[DW+1:0] (result side).
module csa_resolve #(
    parameter int DW = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] s,
    input  logic [DW-1:0] c,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW+1:0] sum
);

    localparam int W    = DW + 2;
    localparam int N    = (W + CW - 1) / CW;
    localparam int CNTW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic [CNTW-1:0] cnt;
    logic            carry_q;

    int              base;
    logic [CW-1:0]   a_sl;
    logic [CW-1:0]   b_sl;
    logic [CW:0]     res;
    logic [W-1:0]    nxt;

    // Slice k lives at bit offset k*CW. Bits of the top slice that would
    // fall above W are shifted out, which acts as the zero padding.
    always_comb begin
        base = int'(cnt) * CW;
        a_sl = CW'(a_q >> base);
        b_sl = CW'(b_q >> base);
        res  = {1'b0, a_sl} + {1'b0, b_sl} + {{CW{1'b0}}, carry_q};
        nxt  = (sum_q & ~(W'({CW{1'b1}}) << base))
             | (W'(res[CW-1:0]) << base);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= {2'b00, s};
                        b_q     <= {1'b0, c, 1'b0};
                        cnt     <= '0;
                        carry_q <= 1'b0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    sum_q   <= nxt;
                    carry_q <= res[CW];
                    if (cnt == LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;

endmodule

// File: tb/tb_csa_resolve.sv
// tb_csa_resolve: directed scoreboard bench for csa_resolve
// (DW=8/CW=4 and DW=16/CW=16 instances).
module tb_csa_resolve;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv_a = 1'b0;
    logic        ir_a;
    logic [7:0]  s_a = '0;
    logic [7:0]  c_a = '0;
    logic        ov_a;
    logic        or_a = 1'b0;
    logic [9:0]  sum_a;

    logic        iv_b = 1'b0;
    logic        ir_b;
    logic [15:0] s_b = '0;
    logic [15:0] c_b = '0;
    logic        ov_b;
    logic        or_b = 1'b0;
    logic [17:0] sum_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0]  q_a[$];
    logic [17:0] q_b[$];

    always #5 clk = ~clk;

    csa_resolve #(.DW(8), .CW(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(iv_a), .in_ready(ir_a),
        .s(s_a), .c(c_a),
        .out_valid(ov_a), .out_ready(or_a),
        .sum(sum_a)
    );

    csa_resolve #(.DW(16), .CW(16)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(iv_b), .in_ready(ir_b),
        .s(s_b), .c(c_b),
        .out_valid(ov_b), .out_ready(or_b),
        .sum(sum_b)
    );

    function automatic logic [9:0] ref_a(logic [7:0] sv, logic [7:0] cv);
        return 10'(sv) + (10'(cv) << 1);
    endfunction

    function automatic logic [17:0] ref_b(logic [15:0] sv, logic [15:0] cv);
        return 18'(sv) + (18'(cv) << 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [7:0] sv, input logic [7:0] cv,
                          input bit push);
        chk("a_accept_ready", 32'(ir_a), 1);
        iv_a = 1'b1;
        s_a  = sv;
        c_a  = cv;
        if (push) q_a.push_back(ref_a(sv, cv));
        @(negedge clk);
        iv_a = 1'b0;
        chk("a_post_accept_ready", 32'(ir_a), 0);
    endtask

    task automatic wait_out_a(input int exp_lat, input bit scramble);
        int lat;
        logic [9:0] e;
        lat = 0;
        while (!ov_a && lat < 20) begin
            chk("a_busy_ready", 32'(ir_a), 0);
            if (scramble) begin
                s_a = 8'($urandom);
                c_a = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        chk("a_out_valid", 32'(ov_a), 1);
        if (ov_a) begin
            chk("a_latency", 32'(lat), 32'(exp_lat));
            chk("a_q_nonempty", 32'(q_a.size() > 0), 1);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                chk("a_sum", 32'(sum_a), 32'(e));
            end
            chk("a_done_ready", 32'(ir_a), 0);
        end
    endtask

    task automatic wait_out_b(input int exp_lat);
        int lat;
        logic [17:0] e;
        lat = 0;
        while (!ov_b && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b_out_valid", 32'(ov_b), 1);
        if (ov_b) begin
            chk("b_latency", 32'(lat), 32'(exp_lat));
            chk("b_q_nonempty", 32'(q_b.size() > 0), 1);
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                chk("b_sum", 32'(sum_b), 32'(e));
            end
        end
    endtask

    initial begin : main
        logic [9:0]  held;
        logic [15:0] tb_s[4];
        logic [15:0] tb_c[4];
        logic [17:0] e;
        int cyc;
        int last_acc;
        int n_acc;

        tb_s = '{16'h1234, 16'hFFFF, 16'h0001, 16'h8000};
        tb_c = '{16'h4321, 16'hFFFF, 16'h7FFF, 16'h0000};

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 32'(ov_a), 0);
        chk("rst_sum", 32'(sum_a), 0);
        chk("rst_in_ready", 32'(ir_a), 1);

        // max operands, latency and in_ready through the handshake
        or_a = 1'b1;
        send_a(8'hFF, 8'hFF, 1'b1);
        wait_out_a(3, 1'b0);
        @(negedge clk);
        chk("a_idle_ready", 32'(ir_a), 1);
        chk("a_idle_valid", 32'(ov_a), 0);

        send_a(8'h0F, 8'h01, 1'b1);
        wait_out_a(3, 1'b0);
        @(negedge clk);
        send_a(8'h00, 8'h00, 1'b1);
        wait_out_a(3, 1'b0);
        @(negedge clk);
        send_a(8'hAA, 8'h55, 1'b1);
        wait_out_a(3, 1'b0);
        @(negedge clk);

        // back-pressure with ignored in_valid pulses
        or_a = 1'b0;
        send_a(8'h12, 8'h34, 1'b1);
        wait_out_a(3, 1'b0);
        held = ref_a(8'h12, 8'h34);
        for (int i = 0; i < 5; i++) begin
            iv_a = 1'b1;
            s_a  = 8'(i * 17);
            c_a  = 8'(i * 3);
            @(negedge clk);
            chk("bp_valid", 32'(ov_a), 1);
            chk("bp_sum", 32'(sum_a), 32'(held));
            chk("bp_ready", 32'(ir_a), 0);
        end
        iv_a = 1'b0;
        or_a = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(ir_a), 1);
        chk("bp_release_valid", 32'(ov_a), 0);
        chk("bp_retain_sum", 32'(sum_a), 32'(held));
        @(negedge clk);
        chk("bp_no_phantom", 32'(ir_a), 1);

        // operands sampled only at acceptance
        send_a(8'h01, 8'h01, 1'b1);
        wait_out_a(3, 1'b1);
        @(negedge clk);

        // reset one cycle after acceptance aborts the operation
        send_a(8'h77, 8'h77, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", 32'(ov_a), 0);
        chk("abort_sum", 32'(sum_a), 0);
        chk("abort_ready", 32'(ir_a), 1);
        send_a(8'h10, 8'h08, 1'b1);
        wait_out_a(3, 1'b0);
        @(negedge clk);

        // wide instance, single-slice-plus-pad geometry
        or_b = 1'b1;
        chk("b_idle_ready", 32'(ir_b), 1);
        iv_b = 1'b1;
        s_b  = 16'hFFFF;
        c_b  = 16'h8000;
        q_b.push_back(ref_b(16'hFFFF, 16'h8000));
        @(negedge clk);
        iv_b = 1'b0;
        wait_out_b(2);
        @(negedge clk);

        // back-to-back acceptances with in_valid held high
        iv_b     = 1'b1;
        cyc      = 0;
        last_acc = -1;
        n_acc    = 0;
        while (cyc < 40 && (n_acc < 4 || q_b.size() > 0)) begin
            if (ov_b) begin
                chk("b2b_q_nonempty", 32'(q_b.size() > 0), 1);
                if (q_b.size() > 0) begin
                    e = q_b.pop_front();
                    chk("b2b_sum", 32'(sum_b), 32'(e));
                end
            end
            if (ir_b && iv_b) begin
                s_b = tb_s[n_acc];
                c_b = tb_c[n_acc];
                q_b.push_back(ref_b(tb_s[n_acc], tb_c[n_acc]));
                if (last_acc >= 0)
                    chk("b2b_interval", 32'(cyc - last_acc), 4);
                last_acc = cyc;
                n_acc++;
            end
            @(negedge clk);
            if (n_acc == 4) iv_b = 1'b0;
            cyc++;
        end
        iv_b = 1'b0;
        chk("b2b_accepts", 32'(n_acc), 4);
        chk("b2b_drained", 32'(q_b.size()), 0);
        chk("a_drained", 32'(q_a.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
